// File: rtl/uart_rx_engine_pkg.sv
// Shared UART definitions: counter width, FSM state encoding, baud-table ROM.
// Shared by the receive and transmit engines.
package uart_rx_engine_pkg;

  localparam int unsigned CntW = 19;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StShift,
    StDone
  } rx_state_e;

  // Clock counts per bit for 100 MHz. Unused codes fall back to the 115200 entry.
  function automatic logic [CntW-1:0] baud_count(input logic [3:0] sel);
    case (sel)
      4'h0:    return 19'd333333;
      4'h1:    return 19'd83333;
      4'h2:    return 19'd41667;
      4'h3:    return 19'd20833;
      4'h4:    return 19'd10417;
      4'h5:    return 19'd5208;
      4'h6:    return 19'd2604;
      4'h7:    return 19'd1736;
      4'h8:    return 19'd868;
      4'h9:    return 19'd434;
      4'hA:    return 19'd217;
      4'hB:    return 19'd109;
      default: return 19'd868;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_engine_baud_sel.sv
// BAUD index to bit-time count lookup (combinational ROM).
// Shared with the transmit engine.
module uart_rx_engine_baud_sel
  import uart_rx_engine_pkg::*;
(
  input  logic [3:0]      i_baud,
  output logic [CntW-1:0] o_count
);

  assign o_count = baud_count(i_baud);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes RX, recovers start/data/parity/stop frames and
// presents the byte with parity, framing and overrun status.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic [3:0] BAUD,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam logic [CntW-1:0] DivW = CntW'(BIT_DIV);

  rx_state_e       r_state;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] r_k;
  logic [3:0]      r_bit_idx;
  logic [9:0]      r_shift;
  logic            r_eight;
  logic            r_pen;
  logic            r_ohel;
  logic [7:0]      r_rx_data;
  logic            r_rxrdy;
  logic            r_perr;
  logic            r_ferr;
  logic            r_ovf;

  logic [CntW-1:0] w_table_cnt;
  logic [CntW-1:0] w_k;
  logic [CntW-1:0] w_half;
  logic [CntW-1:0] w_k_m1;
  logic [3:0]      w_nbits;
  logic [9:0]      w_frame;
  logic [7:0]      w_data;
  logic            w_par;
  logic            w_stop;
  logic            w_perr;

  uart_rx_engine_baud_sel u_baud_sel (
    .i_baud  (BAUD),
    .o_count (w_table_cnt)
  );

  assign w_k     = w_table_cnt / DivW;
  assign w_half  = r_k >> 1;
  assign w_k_m1  = r_k - 1'b1;
  assign w_nbits = (r_eight ? 4'd9 : 4'd8) + {3'b000, r_pen};

  // Bits enter at the MSB, so the received frame sits in the top w_nbits positions.
  assign w_frame = r_shift >> (4'd10 - w_nbits);
  assign w_data  = r_eight ? w_frame[7:0] : {1'b0, w_frame[6:0]};
  assign w_par   = r_eight ? w_frame[8] : w_frame[7];
  assign w_stop  = w_frame[w_nbits - 4'd1];
  assign w_perr  = r_pen & ((^w_data ^ w_par) != r_ohel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_cnt     <= '0;
      r_k       <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_eight   <= 1'b0;
      r_pen     <= 1'b0;
      r_ohel    <= 1'b0;
      r_rx_data <= '0;
      r_rxrdy   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
      if (clr_rdy) begin
        r_rxrdy <= 1'b0;
        r_ovf   <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (!r_rx_s) begin
            r_state <= StStart;
            r_cnt   <= '0;
            r_eight <= EIGHT;
            r_pen   <= PEN;
            r_ohel  <= OHEL;
            r_k     <= w_k;
          end
        end
        StStart: begin
          if (r_cnt == w_half) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? StIdle : StShift;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StShift: begin
          if (r_cnt == w_k_m1) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[9:1]};
            if (r_bit_idx == w_nbits - 4'd1) begin
              r_state <= StDone;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_rx_data <= w_data;
          r_perr    <= w_perr;
          r_ferr    <= ~w_stop;
          r_rxrdy   <= 1'b1;
          // A coincident read retires the old byte, so ovf keeps its value.
          r_ovf     <= r_ovf | (r_rxrdy & ~clr_rdy);
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign rxrdy   = r_rxrdy;
  assign perr    = r_perr;
  assign ferr    = r_ferr;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: directed and random frames against a behavioural model.
module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       eight, pen, ohel;
  logic [3:0] baud_a, baud_b;
  logic       clr_a, clr_b;
  logic [7:0] data_a, data_b;
  logic       rdy_a, perr_a, ferr_a, ovf_a;
  logic       rdy_b, perr_b, ferr_b, ovf_b;

  always #5 clk = ~clk;

  uart_rx_engine #(.BIT_DIV(1)) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx_a),
    .EIGHT   (eight),
    .PEN     (pen),
    .OHEL    (ohel),
    .BAUD    (baud_a),
    .clr_rdy (clr_a),
    .rx_data (data_a),
    .rxrdy   (rdy_a),
    .perr    (perr_a),
    .ferr    (ferr_a),
    .ovf     (ovf_a)
  );

  uart_rx_engine #(.BIT_DIV(8)) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx_b),
    .EIGHT   (eight),
    .PEN     (pen),
    .OHEL    (ohel),
    .BAUD    (baud_b),
    .clr_rdy (clr_b),
    .rx_data (data_b),
    .rxrdy   (rdy_b),
    .perr    (perr_b),
    .ferr    (ferr_b),
    .ovf     (ovf_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  int table_cnt [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                         868, 434, 217, 109, 868, 868, 868, 868};

  // Reference model state per DUT (index 0 = a, 1 = b)
  logic [7:0] m_data [2];
  bit         m_rdy  [2];
  bit         m_ovf  [2];
  bit         m_perr [2];
  bit         m_ferr [2];

  function automatic int kval(input logic [3:0] b, input int div);
    return table_cnt[b] / div;
  endfunction

  function automatic logic [7:0] mask_data(input logic [7:0] d, input bit e);
    return e ? d : (d & 8'h7F);
  endfunction

  function automatic bit par_bit(input logic [7:0] dm, input bit o, input bit flip);
    return (^dm) ^ o ^ flip;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input int sel);
    if (sel == 0) begin
      chk({tag, "_data"}, {24'd0, data_a}, {24'd0, m_data[0]});
      chk({tag, "_rdy"},  {31'd0, rdy_a},  {31'd0, m_rdy[0]});
      chk({tag, "_perr"}, {31'd0, perr_a}, {31'd0, m_perr[0]});
      chk({tag, "_ferr"}, {31'd0, ferr_a}, {31'd0, m_ferr[0]});
      chk({tag, "_ovf"},  {31'd0, ovf_a},  {31'd0, m_ovf[0]});
    end else begin
      chk({tag, "_data"}, {24'd0, data_b}, {24'd0, m_data[1]});
      chk({tag, "_rdy"},  {31'd0, rdy_b},  {31'd0, m_rdy[1]});
      chk({tag, "_perr"}, {31'd0, perr_b}, {31'd0, m_perr[1]});
      chk({tag, "_ferr"}, {31'd0, ferr_b}, {31'd0, m_ferr[1]});
      chk({tag, "_ovf"},  {31'd0, ovf_b},  {31'd0, m_ovf[1]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = '0;
      m_rdy[i]  = 1'b0;
      m_ovf[i]  = 1'b0;
      m_perr[i] = 1'b0;
      m_ferr[i] = 1'b0;
    end
  endtask

  task automatic model_frame(input int sel, input logic [7:0] d, input bit e, input bit p,
                             input bit o, input bit flip, input bit stopv, input bit clr_same);
    logic [7:0] dm;
    dm = mask_data(d, e);
    m_data[sel] = dm;
    m_ferr[sel] = !stopv;
    m_perr[sel] = p && (((^dm) ^ par_bit(dm, o, flip)) != o);
    if (m_rdy[sel] && !clr_same) m_ovf[sel] = 1'b1;
    m_rdy[sel] = 1'b1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  // Drives one frame starting at the current negedge, k clocks per bit.
  task automatic send_frame(input int sel, input int k, input logic [7:0] d, input bit e,
                            input bit p, input bit o, input bit flip, input bit stopv);
    logic [7:0] dm;
    bit bits[$];
    dm = mask_data(d, e);
    bits.push_back(1'b0);
    for (int i = 0; i < (e ? 8 : 7); i++) bits.push_back(dm[i]);
    if (p) bits.push_back(par_bit(dm, o, flip));
    bits.push_back(stopv);
    foreach (bits[i]) begin
      set_rx(sel, bits[i]);
      repeat (k) @(negedge clk);
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic pulse_clr(input int sel);
    if (sel == 0) clr_a = 1'b1;
    else clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    m_rdy[sel] = 1'b0;
    m_ovf[sel] = 1'b0;
  endtask

  task automatic rx_frame_chk(input int sel, input int k, input logic [7:0] d, input bit e,
                              input bit p, input bit o, input bit flip, input bit stopv,
                              input string tag);
    eight = e;
    pen   = p;
    ohel  = o;
    send_frame(sel, k, d, e, p, o, flip, stopv);
    model_frame(sel, d, e, p, o, flip, stopv, 1'b0);
    check_outputs(tag, sel);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int k;
    int m;
    logic [7:0] rd;
    bit re, rp, ro, rf, rs;

    rst    = 1'b1;
    rx_a   = 1'b1;
    rx_b   = 1'b1;
    eight  = 1'b1;
    pen    = 1'b0;
    ohel   = 1'b0;
    baud_a = 4'h8;
    baud_b = 4'h4;
    clr_a  = 1'b0;
    clr_b  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset_a", 0);
    check_outputs("reset_b", 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 at K=868, with rxrdy timed against the stop-bit mid-sample
    k = kval(4'h8, 1);
    m = k / 2 + 4 + k * 9;
    fork
      send_frame(0, k, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (m) @(posedge clk);
        @(negedge clk);
        chk("t1_rdy_before_done", {31'd0, rdy_a}, 32'd0);
        @(negedge clk);
        chk("t1_rdy_after_done", {31'd0, rdy_a}, 32'd1);
      end
    join
    model_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_outputs("t1", 0);
    pulse_clr(0);
    check_outputs("t1_clr", 0);
    repeat (k) @(negedge clk);

    // Low glitch shorter than half a bit is a false start
    rx_a = 1'b0;
    repeat (300) @(negedge clk);
    rx_a = 1'b1;
    repeat (k) @(negedge clk);
    check_outputs("t4_glitch", 0);

    // Remaining dut_a traffic runs at K=109
    baud_a = 4'hB;
    k = kval(4'hB, 1);
    rx_frame_chk(0, k, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "t2_odd_ok");
    pulse_clr(0);
    rx_frame_chk(0, k, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t2_odd_bad");
    pulse_clr(0);
    rx_frame_chk(0, k, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "t2_7bit_even");
    pulse_clr(0);
    rx_frame_chk(0, k, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t3_ferr");
    pulse_clr(0);
    rx_frame_chk(0, k, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t3_good");
    pulse_clr(0);

    // Back-to-back frames without a read, then a read coincident with the third DONE
    eight = 1'b1;
    pen   = 1'b0;
    ohel  = 1'b0;
    send_frame(0, k, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    model_frame(0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(0, k, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    model_frame(0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_outputs("t5_overrun", 0);
    m = k / 2 + 4 + k * 9;
    fork
      send_frame(0, k, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (m) @(posedge clk);
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
      end
    join
    model_frame(0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_outputs("t5_clr_at_done", 0);
    repeat (k) @(negedge clk);

    // Reset during data bits, held until the aborted frame has passed
    fork
      send_frame(0, k, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (4 * k) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("t6_rst", 0);
      end
    join
    repeat (k) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rx_frame_chk(0, k, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t6_after_rst");

    // Random frames: config, data, parity faults, framing faults and reads
    for (int i = 0; i < 14; i++) begin
      rd = 8'($urandom);
      re = 1'($urandom);
      rp = 1'($urandom);
      ro = 1'($urandom);
      rf = ($urandom_range(3, 0) == 0);
      rs = ($urandom_range(4, 0) != 0);
      if ($urandom_range(1, 0) == 1) pulse_clr(0);
      rx_frame_chk(0, k, rd, re, rp, ro, rf, rs, $sformatf("rnd%0d", i));
    end

    // dut_b: BIT_DIV=8, BAUD=4 then BAUD=8
    baud_b = 4'h4;
    k = kval(4'h4, 8);
    rx_frame_chk(1, k, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "div8_baud4");
    pulse_clr(1);
    check_outputs("div8_clr", 1);
    baud_b = 4'h8;
    k = kval(4'h8, 8);
    rd = 8'($urandom);
    rx_frame_chk(1, k, rd, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "div8_baud8");
    rx_frame_chk(1, k, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "div8_ovf");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
